// File: rtl/memory_lsu_stage.sv
`default_nettype none
// ============================================================================
// memory_lsu_stage : pipeline MEM stage with req/ready data port, store lane
//                    alignment, load extraction and the MEM/WB register.
// Optional: MISALIGN_TRAP_EN adds misaligned-access suppression + misalign_o.
// Revision: 1.0
// ============================================================================
module memory_lsu_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_write_m_i,
  input  logic [1:0]      result_src_m_i,
  input  logic            reg_write_m_i,
  input  logic [1:0]      data_memory_size_m_i,
  input  logic            data_memory_sign_m_i,
  input  logic [XLEN-1:0] alu_result_m_i,
  input  logic [XLEN-1:0] write_data_m_i,
  input  logic [XLEN-1:0] pc_plus4_m_i,
  input  logic [4:0]      rd_m_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ready_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_m_o,
  output logic            reg_write_w_o,
  output logic [1:0]      result_src_w_o,
  output logic [4:0]      rd_w_o,
  output logic [XLEN-1:0] read_data_w_o,
  output logic [XLEN-1:0] alu_result_w_o,
  output logic [XLEN-1:0] pc_plus4_w_o,
  output logic            dmem_timeout_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_o
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] c_wait_last = 8'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        w_wait_cnt_nxt;
  logic              w_is_load;
  logic              w_access;
  logic              w_misalign;
  logic              w_issue;
  logic              w_req;
  logic              w_timeout_hit;
  logic              w_stall;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rdata_eff;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_sext;
  logic [XLEN-1:0]   w_load_data;

  assign w_is_load = (result_src_m_i == 2'b01);
  assign w_access  = mem_write_m_i | w_is_load;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_access) begin
      if (data_memory_size_m_i == 2'b01) begin
        w_misalign = alu_result_m_i[0];
      end else if (data_memory_size_m_i[1]) begin
        w_misalign = (alu_result_m_i[1:0] != 2'b00);
      end
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = w_access & ~w_misalign;
  // Reset gates the request combinationally so it drops before the clock edge.
  assign w_req   = ~rst_i & (w_issue | (r_state == WAIT));
  assign w_stall = w_req & ~dmem_ready_i & ~w_timeout_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_hit  = 1'b0;
    case (r_state)
      IDLE: begin
        w_wait_cnt_nxt = '0;
        if (w_req && !dmem_ready_i) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ready_i) begin
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == c_wait_last) begin
          w_timeout_hit  = 1'b1;
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data_m_i;
    case (data_memory_size_m_i)
      2'b00: begin
        w_be    = 4'b0001 << alu_result_m_i[1:0];
        w_wdata = {4{write_data_m_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {alu_result_m_i[1], 1'b0};
        w_wdata = {2{write_data_m_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = write_data_m_i;
      end
    endcase
  end

  assign dmem_req_o   = w_req;
  assign dmem_we_o    = mem_write_m_i;
  assign dmem_addr_o  = {alu_result_m_i[XLEN-1:2], 2'b00};
  assign dmem_be_o    = w_be;
  assign dmem_wdata_o = w_wdata;
  assign stall_m_o    = w_stall;

  // An abandoned access completes with an all-zero word.
  assign w_rdata_eff = w_timeout_hit ? '0 : dmem_rdata_i;
  assign w_sext      = ~data_memory_sign_m_i;

  always_comb begin
    w_byte = w_rdata_eff[7:0];
    case (alu_result_m_i[1:0])
      2'b00:   w_byte = w_rdata_eff[7:0];
      2'b01:   w_byte = w_rdata_eff[15:8];
      2'b10:   w_byte = w_rdata_eff[23:16];
      default: w_byte = w_rdata_eff[31:24];
    endcase
  end

  assign w_half = alu_result_m_i[1] ? w_rdata_eff[31:16] : w_rdata_eff[15:0];

  always_comb begin
    w_load_data = w_rdata_eff;
    case (data_memory_size_m_i)
      2'b00:   w_load_data = {{(XLEN-8){w_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{(XLEN-16){w_sext & w_half[15]}}, w_half};
      default: w_load_data = w_rdata_eff;
    endcase
  end

  // While stalled the register captures a bubble so rd is written exactly once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_write_w_o  <= 1'b0;
      result_src_w_o <= '0;
      rd_w_o         <= '0;
      read_data_w_o  <= '0;
      alu_result_w_o <= '0;
      pc_plus4_w_o   <= '0;
      dmem_timeout_o <= 1'b0;
    end else begin
      reg_write_w_o  <= reg_write_m_i & ~w_stall & ~w_misalign;
      result_src_w_o <= result_src_m_i;
      rd_w_o         <= rd_m_i;
      read_data_w_o  <= (w_is_load && w_issue) ? w_load_data : '0;
      alu_result_w_o <= alu_result_m_i;
      pc_plus4_w_o   <= pc_plus4_m_i;
      dmem_timeout_o <= w_timeout_hit;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= w_misalign;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_lsu_stage.sv
`default_nettype none
// ============================================================================
// tb_memory_lsu_stage : directed vectors with a behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_memory_lsu_stage;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write;
  logic [1:0]  result_src;
  logic        reg_write;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] pc_plus4;
  logic [4:0]  rd;
  logic        ready;
  logic [31:0] rdata;

  logic        dmem_req, dmem_we, stall;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        reg_write_w, dmem_timeout;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] read_data_w, alu_result_w, pc_plus4_w;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  memory_lsu_stage #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_write_m_i(mem_write), .result_src_m_i(result_src), .reg_write_m_i(reg_write),
    .data_memory_size_m_i(size), .data_memory_sign_m_i(sign),
    .alu_result_m_i(alu_result), .write_data_m_i(write_data), .pc_plus4_m_i(pc_plus4),
    .rd_m_i(rd),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_ready_i(ready), .dmem_rdata_i(rdata),
    .stall_m_o(stall),
    .reg_write_w_o(reg_write_w), .result_src_w_o(result_src_w), .rd_w_o(rd_w),
    .read_data_w_o(read_data_w), .alu_result_w_o(alu_result_w), .pc_plus4_w_o(pc_plus4_w),
    .dmem_timeout_o(dmem_timeout)
`ifdef MISALIGN_TRAP_EN
    , .misalign_o(misalign)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load result from the architectural rule: pick lane, then extend.
  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (word >> (8 * a[1:0])) & 32'hFF;
      if (!sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (word >> (16 * a[1])) & 32'hFFFF;
      if (!sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 4'(1 << (a % 4));
    if (sz == 2'b01) return 4'(3 << (a & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  typedef struct packed {
    logic        valid;
    logic        full;
    logic        load;
    logic        rw;
    logic        tmo;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] rdat;
  } wexp_t;

  wexp_t ew = '0;
  int    waited = 0;

  // Reference model: waited = stalled cycles so far for the current access.
  always @(negedge clk) begin
    logic acc, tmo, stl;
    if (ew.valid) begin
      chk("w_reg_write", 32'(reg_write_w), 32'(ew.rw));
      chk("w_timeout", 32'(dmem_timeout), 32'(ew.tmo));
      if (ew.full) begin
        chk("w_result_src", 32'(result_src_w), 32'(ew.rs));
        chk("w_rd", 32'(rd_w), 32'(ew.rd));
        chk("w_alu", alu_result_w, ew.alu);
        chk("w_pc4", pc_plus4_w, ew.pc4);
      end
      if (ew.load) chk("w_read_data", read_data_w, ew.rdat);
    end
    if (rst) begin
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      ew       = '0;
      ew.valid = 1'b1;
      ew.full  = 1'b1;
      ew.load  = 1'b1;
      waited   = 0;
    end else begin
      acc = mem_write | (result_src == 2'b01);
      tmo = acc && !ready && (waited == T);
      stl = acc && !ready && !tmo;
      chk("req", 32'(dmem_req), 32'(acc));
      chk("stall", 32'(stall), 32'(stl));
      if (acc) begin
        chk("addr", dmem_addr, alu_result & 32'hFFFF_FFFC);
        chk("we", 32'(dmem_we), 32'(mem_write));
        if (mem_write) begin
          chk("be", 32'(dmem_be), 32'(mdl_be(size, alu_result)));
          chk("wdata", dmem_wdata, mdl_wdata(size, write_data));
        end
      end
      ew       = '0;
      ew.valid = 1'b1;
      if (!stl) begin
        ew.full = 1'b1;
        ew.rw   = reg_write;
        ew.tmo  = tmo;
        ew.rs   = result_src;
        ew.rd   = rd;
        ew.alu  = alu_result;
        ew.pc4  = pc_plus4;
        ew.load = (result_src == 2'b01);
        ew.rdat = tmo ? 32'd0 : mdl_load(size, sign, alu_result, rdata);
      end
      waited = stl ? waited + 1 : 0;
    end
  end

  task automatic drive(input logic mw, input logic [1:0] rs, input logic rw,
                       input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] r);
    mem_write = mw; result_src = rs; reg_write = rw; size = sz; sign = sg;
    alu_result = a; write_data = wd; pc_plus4 = pc4; rd = r;
  endtask

  // Upstream behaviour: hold the instruction until the memory completes or times out.
  task automatic run(input int delay, input logic [31:0] word, output int stalls, output int writes);
    int   hold;
    logic acc;
    acc    = mem_write | (result_src == 2'b01);
    hold   = acc ? (((delay < T) ? delay : T) + 1) : 1;
    stalls = 0;
    writes = 0;
    for (int i = 0; i < hold; i++) begin
      ready = acc && (i == delay);
      rdata = word;
      @(negedge clk);
      if (stall) stalls++;
      @(posedge clk);
      #1;
      if (reg_write_w) writes++;
    end
    ready = 1'b0;
  endtask

  typedef struct {
    logic        mw;
    logic [1:0]  rs;
    logic        rw;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] word;
    int          delay;
  } vec_t;

  vec_t vecs[12] = '{
    '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_00A5, 32'h0, 0},
    '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h1122_3377, 32'h0, 1},
    '{1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 0},
    '{1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 32'h0000_020C, 32'h8765_4321, 32'h0, 2},
    '{1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 32'h0000_0210, 32'h0BAD_CAFE, 32'h0, 0},
    '{1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0},
    '{1'b0, 2'b01, 1'b1, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1},
    '{1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 32'h8001_7FFF, 0},
    '{1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0, 32'h1234_F6A0, 0},
    '{1'b0, 2'b01, 1'b1, 2'b11, 1'b0, 32'h0000_0204, 32'h0, 32'h5A5A_A5A5, 0},
    '{1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 0},
    '{1'b0, 2'b10, 1'b1, 2'b10, 1'b0, 32'h0000_0077, 32'h0, 32'h0, 0}
  };

  initial begin
    int s, w;
    rst = 1'b1;
    ready = 1'b0;
    rdata = '0;
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("reset_read_data_w", read_data_w, 32'd0);
    chk("reset_alu_w", alu_result_w, 32'd0);
    chk("reset_timeout", 32'(dmem_timeout), 32'd0);
    rst = 1'b0;

    drive(1'b0, 2'b01, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_1004, 5'd1);
    run(0, 32'hDEADBEEF, s, w);
    chk("lw_stalls", 32'(s), 32'd0);
    chk("lw_data", read_data_w, 32'hDEADBEEF);
    chk("lw_reg_write", 32'(reg_write_w), 32'd1);

    drive(1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_1008, 5'd2);
    run(0, 32'h80AABBCC, s, w);
    chk("lb_data", read_data_w, 32'hFFFFFF80);
    drive(1'b0, 2'b01, 1'b1, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_100C, 5'd3);
    run(0, 32'h80AABBCC, s, w);
    chk("lbu_data", read_data_w, 32'h00000080);

    drive(1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h1234ABCD, 32'h0000_1010, 5'd0);
    #1;
    chk("sh_addr", dmem_addr, 32'h0000_0100);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(dmem_we), 32'd1);
    run(0, 32'h0, s, w);

    drive(1'b0, 2'b01, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h0000_1014, 5'd4);
    run(3, 32'h0F0F_1234, s, w);
    chk("lw_wait_stalls", 32'(s), 32'd3);
    chk("lw_wait_writes", 32'(w), 32'd1);
    chk("lw_wait_data", read_data_w, 32'h0F0F_1234);

    drive(1'b0, 2'b01, 1'b1, 2'b10, 1'b0, 32'h0000_0108, 32'h0, 32'h0000_1018, 5'd5);
    run(1000, 32'hFFFF_FFFF, s, w);
    chk("tmo_stalls", 32'(s), 32'(T));
    chk("tmo_pulse", 32'(dmem_timeout), 32'd1);
    chk("tmo_data", read_data_w, 32'd0);

    drive(1'b0, 2'b01, 1'b1, 2'b10, 1'b0, 32'h0000_010C, 32'h0, 32'h0000_101C, 5'd6);
    ready = 1'b0;
    rdata = 32'h1357_9BDF;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_alu_w", alu_result_w, 32'd0);
    chk("arst_rd_w", 32'(rd_w), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 2'b01, 1'b1, 2'b10, 1'b0, 32'h0000_0110, 32'h0, 32'h0000_1020, 5'd7);
    run(1, 32'h1122_3344, s, w);
    chk("after_rst_stalls", 32'(s), 32'd1);
    chk("after_rst_data", read_data_w, 32'h1122_3344);

    foreach (vecs[i]) begin
      drive(vecs[i].mw, vecs[i].rs, vecs[i].rw, vecs[i].sz, vecs[i].sg, vecs[i].a,
            vecs[i].wd, 32'h0000_2000 + 32'(i * 4), 5'(i + 8));
      run(vecs[i].delay, vecs[i].word, s, w);
    end

    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
